level_shifter_bank: RTL and testbench
=====================================

Name: level_shifter_bank

Overview:
- Clocked, multi-channel low-to-high voltage level shifter for the DAC top level, with real-valued outputs.
- Replaces the single-channel combinational shifter.
- Adds per-channel registered inputs, supply power-good qualification, a power-up settle phase, supply-drop fault handling and per-channel output enables.
- Sits between the digital DAC code/control logic (VCC_LOW domain) and the analog switch drivers (VCC_HIGH domain).

Parameters:
- N_CH, 8, number of shifted channels (1..32).
- VLOW_MIN, 1.0 (real, V), minimum VCC_LOW for supply-good.
- VHIGH_MIN, 2.5 (real, V), minimum VCC_HIGH for supply-good.
- PG_CYCLES, 16, consecutive supply-good cycles required before settling (≥1).
- SETTLE_CYCLES, 4, cycles outputs are held at 0.0 after power-good (≥1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  bank enable; deassertion returns to OFF and clears the fault.
- ch_en  input  N_CH  per-channel output enable.
- VIN  input  N_CH  logic inputs, VCC_LOW domain.
- VCC_LOW  input  real  low-side supply voltage.
- VCC_HIGH  input  real  high-side supply voltage.
- VOUT  output  real[N_CH]  shifted outputs, 0.0 or VCC_HIGH.
- ready  output  1  high only in ACTIVE.
- fault  output  1  sticky supply-drop flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=OFF, pg_cnt=0, set_cnt=0, vin_q=0.
  - VOUT[i]=0.0 for all i; ready=0; fault=0.
- supply_ok = (VCC_LOW >= VLOW_MIN) && (VCC_HIGH >= VHIGH_MIN), evaluated combinationally every cycle.
- OFF: VOUT all 0.0, ready=0. If en=1, go to WAIT_PG next edge with pg_cnt=0.
- WAIT_PG:
  - supply_ok=1: pg_cnt increments.
  - supply_ok=0: pg_cnt clears to 0.
  - When pg_cnt reaches PG_CYCLES-1 with supply_ok=1, go to SETTLE with set_cnt=0. Entry to SETTLE is therefore exactly PG_CYCLES consecutive good cycles after entering WAIT_PG.
  - en=0: go to OFF.
- SETTLE:
  - VOUT all 0.0; vin_q samples VIN every cycle.
  - set_cnt increments; go to ACTIVE after SETTLE_CYCLES cycles.
  - supply_ok=0: return to WAIT_PG, pg_cnt=0, no fault.
  - en=0: go to OFF.
- ACTIVE:
  - ready=1; vin_q <= VIN every edge.
  - VOUT[i] = (vin_q[i] && ch_en[i]) ? VCC_HIGH : 0.0.
  - Latency: one clk from VIN to VOUT. ch_en acts combinationally on the registered data.
  - VOUT tracks the live VCC_HIGH value while driven high.
- FAULT entry and behaviour:
  - In ACTIVE, supply_ok=0 for one sampled edge: go to FAULT, set fault=1. On that same edge VOUT goes to 0.0 and ready to 0.
  - In FAULT: VOUT all 0.0, ready=0, fault held at 1 regardless of supply recovery.
  - Exit only via en=0 (to OFF, fault cleared) or reset.
- Priority at each edge: rst_n > en=0 > supply check > counters.
- Simultaneous en=0 and supply drop in ACTIVE: go to OFF, fault stays 0.
- Reset mid-operation: immediate return to reset values, including during FAULT.
- VIN changes outside ACTIVE never reach VOUT.
- pg_cnt and set_cnt are sized $clog2(max(PG_CYCLES,SETTLE_CYCLES)+1) and saturate; they never wrap.
- N_CH=1 behaves identically on channel 0.

Test Plan:
- Power-up: en=1, VCC_LOW=1.2, VCC_HIGH=3.3, VIN=8'hA5, ch_en=8'hFF.
  - ready rises exactly 16+4+1 edges after en.
  - VOUT = {3.3,0,3.3,0,0,3.3,0,3.3}, MSB first; never nonzero before ready.
- Power-good glitch: VCC_HIGH=2.0 for 1 cycle at pg_cnt=10.
  - pg_cnt clears; ready delayed by 11 cycles.
  - fault stays 0.
- Data latency and enable masking: in ACTIVE, VIN 8'h00→8'hFF at edge k.
  - All VOUT=3.3 at edge k+1.
  - Set ch_en=8'h0F: VOUT[7:4]=0.0 the same cycle.
- Supply drop: in ACTIVE, VCC_LOW=0.5.
  - Next edge: fault=1, ready=0, all VOUT=0.0.
  - Restore VCC_LOW=1.2: fault still 1.
  - en=0 for 1 cycle, then en=1: fault clears and the full sequence repeats.
- Tracking: in ACTIVE with VIN=8'hFF, ramp VCC_HIGH 3.3→3.0.
  - VOUT follows 3.0; no fault (3.0 ≥ 2.5).
- Reset: assert rst_n=0 mid-ACTIVE and mid-FAULT, asynchronously between edges.
  - VOUT=0.0, ready=0, fault=0 immediately.
  - On release, state=OFF.

Source files
------------

// File: rtl/level_shifter_bank.sv
// rtl/level_shifter_bank.sv - clocked multi-channel low-to-high level shifter with
// supply power-good qualification, settle phase, sticky supply-drop fault and channel enables.
module level_shifter_bank #(
  parameter int  N_CH          = 8,
  parameter real VLOW_MIN      = 1.0,
  parameter real VHIGH_MIN     = 2.5,
  parameter int  PG_CYCLES     = 16,
  parameter int  SETTLE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N_CH-1:0] ch_en,
  input  logic [N_CH-1:0] VIN,
  input  real             VCC_LOW,
  input  real             VCC_HIGH,
  output real             VOUT [N_CH-1:0],
  output logic            ready,
  output logic            fault
);

  localparam int CNT_TOP = (PG_CYCLES > SETTLE_CYCLES) ? PG_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_TOP + 1);
  localparam logic [CNT_W-1:0] PG_LAST  = CNT_W'(PG_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_OFF,
    S_WAIT_PG,
    S_SETTLE,
    S_ACTIVE,
    S_FAULT
  } state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] pg_cnt_q, pg_cnt_d;
  logic [CNT_W-1:0] set_cnt_q, set_cnt_d;
  logic [N_CH-1:0] vin_q, vin_d;
  logic            supply_ok;

  assign supply_ok = (VCC_LOW >= VLOW_MIN) && (VCC_HIGH >= VHIGH_MIN);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_OFF;
      pg_cnt_q  <= '0;
      set_cnt_q <= '0;
      vin_q     <= '0;
    end else begin
      state_q   <= state_d;
      pg_cnt_q  <= pg_cnt_d;
      set_cnt_q <= set_cnt_d;
      vin_q     <= vin_d;
    end
  end

  // Priority: en=0 beats the supply check, which beats the counters.
  always_comb begin
    state_d   = state_q;
    pg_cnt_d  = pg_cnt_q;
    set_cnt_d = set_cnt_q;
    vin_d     = vin_q;
    if (!en) begin
      state_d   = S_OFF;
      pg_cnt_d  = '0;
      set_cnt_d = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d  = S_WAIT_PG;
          pg_cnt_d = '0;
        end
        S_WAIT_PG: begin
          if (!supply_ok) begin
            pg_cnt_d = '0;
          end else if (pg_cnt_q >= PG_LAST) begin
            state_d   = S_SETTLE;
            set_cnt_d = '0;
          end else begin
            pg_cnt_d = sat_inc(pg_cnt_q);
          end
        end
        S_SETTLE: begin
          vin_d = VIN;
          if (!supply_ok) begin
            state_d  = S_WAIT_PG;
            pg_cnt_d = '0;
          end else if (set_cnt_q >= SET_LAST) begin
            state_d = S_ACTIVE;
          end else begin
            set_cnt_d = sat_inc(set_cnt_q);
          end
        end
        S_ACTIVE: begin
          vin_d = VIN;
          if (!supply_ok) state_d = S_FAULT;
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_OFF;
        end
      endcase
    end
  end

  assign ready = (state_q == S_ACTIVE);
  assign fault = (state_q == S_FAULT);

  // Driven-high outputs follow the live high-side supply, not a sampled copy.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      VOUT[i] = 0.0;
      if (ready && vin_q[i] && ch_en[i]) VOUT[i] = VCC_HIGH;
    end
  end

endmodule

// File: tb/tb_level_shifter_bank.sv
// tb/tb_level_shifter_bank.sv - scoreboard bench for level_shifter_bank with a
// power-phase reference model, directed power/fault/reset scenarios and random stimulus.
module tb_level_shifter_bank;

  localparam int N  = 8;
  localparam int PG = 16;
  localparam int ST = 4;

  localparam int M_OFF = 0;
  localparam int M_PWR = 1;
  localparam int M_ACT = 2;
  localparam int M_FLT = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [N-1:0] ch_en;
  logic [N-1:0] VIN;
  real          VCC_LOW;
  real          VCC_HIGH;
  real          VOUT [N-1:0];
  logic         ready;
  logic         fault;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic         ready;
    logic         fault;
    logic [N-1:0] data;
  } exp_t;

  exp_t sb_q[$];

  int           m_mode;
  int           m_run;
  logic [N-1:0] m_vin;

  level_shifter_bank #(
    .N_CH(N), .VLOW_MIN(1.0), .VHIGH_MIN(2.5), .PG_CYCLES(PG), .SETTLE_CYCLES(ST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ch_en(ch_en), .VIN(VIN),
    .VCC_LOW(VCC_LOW), .VCC_HIGH(VCC_HIGH), .VOUT(VOUT), .ready(ready), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_real(input string name, input real act, input real exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %f expected %f at %0t", name, act, exp, $time);
    end
  endtask

  // A channel is at VCC_HIGH only when its data bit and its live enable are both set.
  task automatic check_vout(input string name, input logic [N-1:0] d);
    real exp;
    int  bad = -1;
    real bad_act = 0.0, bad_exp = 0.0;
    n_checks++;
    for (int i = 0; i < N; i++) begin
      exp = (d[i] && ch_en[i]) ? VCC_HIGH : 0.0;
      if (VOUT[i] != exp && bad < 0) begin
        bad = i; bad_act = VOUT[i]; bad_exp = exp;
      end
    end
    if (bad >= 0) begin
      n_errors++;
      $display("FAIL %s: VOUT[%0d] got %f expected %f at %0t", name, bad, bad_act, bad_exp, $time);
    end
  endtask

  // Reference: once enabled, the bank becomes ready after PG+ST consecutive good edges.
  task automatic model_edge();
    logic ok;
    ok = (VCC_LOW >= 1.0) && (VCC_HIGH >= 2.5);
    if (!en) begin
      m_mode = M_OFF;
      m_run  = 0;
    end else begin
      case (m_mode)
        M_OFF: begin m_mode = M_PWR; m_run = 0; end
        M_PWR: begin
          if (ok) begin
            m_run++;
            if (m_run == PG + ST) m_mode = M_ACT;
          end else begin
            m_run = 0;
          end
        end
        M_ACT: if (!ok) m_mode = M_FLT;
        default: m_mode = M_FLT;
      endcase
    end
    m_vin = VIN;
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    model_edge();
    e.ready = (m_mode == M_ACT);
    e.fault = (m_mode == M_FLT);
    e.data  = (m_mode == M_ACT) ? m_vin : '0;
    sb_q.push_back(e);
    #1;
  endtask

  task automatic power_up(output int edges);
    edges = 0;
    while (!ready && edges < 100) begin
      step();
      edges++;
    end
  endtask

  task automatic do_reset(input string tag);
    sb_q.delete();
    rst_n = 1'b0;
    #1;
    check_bit({tag, "_ready"}, ready, 1'b0);
    check_bit({tag, "_fault"}, fault, 1'b0);
    check_vout({tag, "_vout"}, '0);
    m_mode = M_OFF;
    m_run  = 0;
    m_vin  = '0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_bit("sb_ready", ready, e.ready);
      check_bit("sb_fault", fault, e.fault);
      check_vout("sb_vout", e.data);
    end
  end

  initial begin
    int n;
    int r;
    rst_n = 1'b0; en = 1'b0; ch_en = '1; VIN = '0;
    VCC_LOW = 1.2; VCC_HIGH = 3.3;
    m_mode = M_OFF; m_run = 0; m_vin = '0;

    repeat (2) @(posedge clk);
    #1;
    check_bit("reset_ready", ready, 1'b0);
    check_bit("reset_fault", fault, 1'b0);
    check_vout("reset_vout", '0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Power-up with a fixed pattern
    VIN = 8'hA5; en = 1'b1;
    power_up(n);
    check_int("powerup_edges", n, PG + ST + 1);
    check_real("powerup_v7", VOUT[7], 3.3);
    check_real("powerup_v6", VOUT[6], 0.0);
    check_real("powerup_v0", VOUT[0], 3.3);
    check_real("powerup_v1", VOUT[1], 0.0);

    // One-cycle latency and combinational channel masking
    VIN = 8'h00; step();
    VIN = 8'hFF; step();
    check_vout("latency_ff", 8'hFF);
    ch_en = 8'h0F;
    #1;
    check_real("mask_v7", VOUT[7], 0.0);
    check_real("mask_v4", VOUT[4], 0.0);
    check_real("mask_v3", VOUT[3], 3.3);
    ch_en = 8'hFF; step();

    // Tracking the live high-side supply
    VCC_HIGH = 3.2; step();
    VCC_HIGH = 3.1; step();
    VCC_HIGH = 3.0;
    #1;
    check_real("track_v5", VOUT[5], 3.0);
    repeat (3) step();
    check_bit("track_nofault", fault, 1'b0);

    // Supply drop, sticky fault, clear via en
    VCC_LOW = 0.5; step();
    check_bit("drop_fault", fault, 1'b1);
    check_bit("drop_ready", ready, 1'b0);
    check_vout("drop_vout", '0);
    VCC_LOW = 1.2; repeat (3) step();
    check_bit("drop_sticky", fault, 1'b1);
    en = 1'b0; step();
    check_bit("drop_clear", fault, 1'b0);
    en = 1'b1;
    power_up(n);
    check_int("repower_edges", n, PG + ST + 1);

    // Power-good glitch at pg_cnt=10
    en = 1'b0; step();
    en = 1'b1; VCC_HIGH = 3.3;
    step();
    repeat (10) step();
    VCC_HIGH = 2.0; step();
    VCC_HIGH = 3.3;
    power_up(n);
    check_int("glitch_edges", n + 12, PG + ST + 1 + 11);
    check_bit("glitch_nofault", fault, 1'b0);

    // Asynchronous reset mid-ACTIVE and mid-FAULT
    step();
    do_reset("rst_active");
    power_up(n);
    check_int("rst_active_edges", n, PG + ST + 1);
    VCC_HIGH = 2.0; step();
    check_bit("pre_rst_fault", fault, 1'b1);
    VCC_HIGH = 3.3; step();
    do_reset("rst_fault");
    en = 1'b0; step();
    check_bit("post_rst_off", ready, 1'b0);
    en = 1'b1;
    power_up(n);
    check_int("rst_fault_edges", n, PG + ST + 1);

    // Supplies exactly at threshold are good
    VCC_LOW = 1.0; VCC_HIGH = 2.5; VIN = 8'h3C;
    repeat (3) step();
    check_bit("thresh_nofault", fault, 1'b0);
    check_real("thresh_v2", VOUT[2], 2.5);

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      en = ($urandom_range(0, 59) != 0);
      r = $urandom_range(0, 39);
      VCC_LOW = (r == 0) ? 0.5 : ((r == 1) ? 1.0 : 1.2);
      r = $urandom_range(0, 39);
      if (r == 0)      VCC_HIGH = 2.0;
      else if (r == 1) VCC_HIGH = 2.5;
      else begin
        case ($urandom_range(0, 2))
          0:       VCC_HIGH = 3.3;
          1:       VCC_HIGH = 3.0;
          default: VCC_HIGH = 2.7;
        endcase
      end
      VIN   = N'($urandom);
      ch_en = N'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset("rst_random");
      else step();
    end

    en = 1'b0; step();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
